// File: rtl/buscador_vizinhos.sv
// Neighbour expansion: walks a node's relation slots, filters blocked or null
// neighbours via the obstacle RAM and streams free ones over valid/ready.
module buscador_vizinhos #(
    parameter int ADDR_WIDTH = 8,
    parameter int VIZ_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] node_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [VIZ_BITS:0]     n_vizinhos_out,
    output logic                  vizinho_valid_out,
    output logic [ADDR_WIDTH-1:0] vizinho_out,
    input  logic                  vizinho_ready_in,
    output logic                  relacoes_rd_enable_out,
    output logic [ADDR_WIDTH-1:0] relacoes_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0] relacoes_rd_data_in,
    output logic                  obstaculos_rd_enable_out,
    output logic [ADDR_WIDTH-1:0] obstaculos_rd_addr_out,
    input  logic                  obstaculos_rd_data_in
);

    typedef enum logic [2:0] {
        IDLE, LE_REL, ESP_REL, LE_OBS, ESP_OBS, ENTREGA, FIM
    } estado_t;

    localparam logic [VIZ_BITS-1:0] K_UM = VIZ_BITS'(1);
    localparam logic [VIZ_BITS:0]   N_UM = (VIZ_BITS + 1)'(1);

    estado_t                        estado, estado_next;
    logic [ADDR_WIDTH-VIZ_BITS-1:0] node_q;
    logic [VIZ_BITS-1:0]            k_q;
    logic [ADDR_WIDTH-1:0]          cand_q;
    logic [VIZ_BITS:0]              n_viz_q;
    logic                           avanca;

    // Upper node bits do not participate in the relations address.
    logic unused_node_hi;
    assign unused_node_hi = ^node_in[ADDR_WIDTH-1:ADDR_WIDTH-VIZ_BITS];

    assign n_vizinhos_out = n_viz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            node_q  <= '0;
            k_q     <= '0;
            cand_q  <= '0;
            n_viz_q <= '0;
        end else begin
            estado <= estado_next;
            case (estado)
                IDLE: begin
                    if (start_in) begin
                        node_q  <= node_in[ADDR_WIDTH-VIZ_BITS-1:0];
                        k_q     <= '0;
                        n_viz_q <= '0;
                    end
                end
                ESP_REL: cand_q <= relacoes_rd_data_in;
                ENTREGA: begin
                    if (vizinho_ready_in)
                        n_viz_q <= n_viz_q + N_UM;
                end
                default: ;
            endcase
            // k saturates on the last slot so it never wraps within an expansion.
            if (avanca && (k_q != '1))
                k_q <= k_q + K_UM;
        end
    end

    always_comb begin
        estado_next              = estado;
        avanca                   = 1'b0;
        busy_out                 = (estado != IDLE);
        done_out                 = 1'b0;
        vizinho_valid_out        = 1'b0;
        vizinho_out              = '0;
        relacoes_rd_enable_out   = 1'b0;
        relacoes_rd_addr_out     = '0;
        obstaculos_rd_enable_out = 1'b0;
        obstaculos_rd_addr_out   = '0;
        case (estado)
            IDLE: begin
                if (start_in)
                    estado_next = LE_REL;
            end
            LE_REL: begin
                relacoes_rd_enable_out = 1'b1;
                relacoes_rd_addr_out   = {node_q, k_q};
                estado_next            = ESP_REL;
            end
            ESP_REL: begin
                if (relacoes_rd_data_in == '1)
                    avanca = 1'b1;
                else
                    estado_next = LE_OBS;
            end
            LE_OBS: begin
                obstaculos_rd_enable_out = 1'b1;
                obstaculos_rd_addr_out   = cand_q;
                estado_next              = ESP_OBS;
            end
            ESP_OBS: begin
                if (obstaculos_rd_data_in)
                    avanca = 1'b1;
                else
                    estado_next = ENTREGA;
            end
            ENTREGA: begin
                vizinho_valid_out = 1'b1;
                vizinho_out       = cand_q;
                if (vizinho_ready_in)
                    avanca = 1'b1;
            end
            FIM: begin
                done_out    = 1'b1;
                estado_next = IDLE;
            end
            default: estado_next = IDLE;
        endcase
        if (avanca)
            estado_next = (k_q == '1) ? FIM : LE_REL;
    end

endmodule

// File: doc/buscador_vizinhos.md
# buscador_vizinhos

Neighbour-expansion stage that sits directly downstream of the external-access memory manager in the path-planning datapath. Given a node id, it walks that node's relation slots in the relations RAM and checks each neighbour against the obstacle RAM. Each free neighbour is streamed out over a valid/ready handshake to the search core. The block drives both RAMs' read ports, which have one-cycle read latency.

## Interface
Parameters:
- ADDR_WIDTH, 8, node-id width; also the width of the relations and obstacle RAM addresses and of the relations RAM data.
- VIZ_BITS, 2, log2 of the number of relation slots per node (default 4 slots).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  single-cycle request; sampled only in IDLE.
- node_in  in  ADDR_WIDTH  node to expand; captured when start is accepted.
- busy_out  out  1  high whenever state ≠ IDLE.
- done_out  out  1  one-cycle pulse when expansion completes.
- n_vizinhos_out  out  VIZ_BITS+1  number of neighbours delivered in the current or last expansion.
- vizinho_valid_out  out  1  a free neighbour is presented.
- vizinho_out  out  ADDR_WIDTH  neighbour node id.
- vizinho_ready_in  in  1  consumer accepts the neighbour.
- relacoes_rd_enable_out  out  1  relations RAM read enable.
- relacoes_rd_addr_out  out  ADDR_WIDTH  relations RAM read address.
- relacoes_rd_data_in  in  ADDR_WIDTH  relations RAM read data, valid the cycle after the enable.
- obstaculos_rd_enable_out  out  1  obstacle RAM read enable.
- obstaculos_rd_addr_out  out  ADDR_WIDTH  obstacle RAM read address.
- obstaculos_rd_data_in  in  1  obstacle bit, valid the cycle after the enable; 1 means blocked.

## Operation
- Relations layout: slot k of node n is at address {n[ADDR_WIDTH-VIZ_BITS-1:0], k[VIZ_BITS-1:0]}. Upper node bits are dropped.
- A slot value of all-ones means "no neighbour" and is skipped.
- The obstacle RAM is indexed directly by the neighbour id.
- FSM states: IDLE, LE_REL, ESP_REL, LE_OBS, ESP_OBS, ENTREGA, FIM.
- IDLE: on start_in, capture node_in, set k=0, clear n_vizinhos_out, go to LE_REL. start_in is ignored in every other state.
- LE_REL: relacoes_rd_enable_out=1 and address={node,k}. Go to ESP_REL.
- ESP_REL: register relacoes_rd_data_in as the candidate.
  - If the candidate is all-ones, go to the next slot.
  - Otherwise go to LE_OBS.
- LE_OBS: obstaculos_rd_enable_out=1, address=candidate. Go to ESP_OBS.
- ESP_OBS:
  - If obstaculos_rd_data_in=1, go to the next slot.
  - Otherwise go to ENTREGA.
- ENTREGA: vizinho_valid_out=1, vizinho_out=candidate.
  - On the cycle with valid&ready, n_vizinhos_out increments and the FSM goes to the next slot.
  - vizinho_out stays stable while valid&!ready.
- Next slot:
  - If k=2^VIZ_BITS−1, go to FIM.
  - Otherwise k increments and the FSM goes to LE_REL.
  - k must not wrap to 0 within one expansion.
- FIM: done_out=1 for one cycle, then IDLE. n_vizinhos_out holds until the next accepted start.
- Read enables and read addresses are Moore outputs of LE_REL and LE_OBS only. Enables are 0 in every other state; addresses are don't-care when their enable is 0.
- Reset, including mid-expansion: on the next edge go to IDLE. All outputs become 0, no done_out is emitted, and a pending neighbour is dropped.

## Timing
- Cycle 0 is the edge at which start_in is sampled in IDLE. busy_out rises in cycle 1, which is LE_REL for k=0.
- Cost per slot, with ready held high:
  - null slot: 2 cycles;
  - blocked neighbour: 4 cycles;
  - delivered neighbour: 5 cycles, plus 1 extra cycle for each cycle ready is low.
- done_out appears in the cycle after the last slot's final state. busy_out is high in FIM and falls in the following cycle.
- Minimum expansion (all slots null, 4 slots): done_out in cycle 9.
- Back-to-back: a start_in asserted in the first IDLE cycle after FIM is accepted.

## Test plan
- Reset values: assert rst for 2 cycles → every output is 0 and the FSM is in IDLE; start_in held during reset is ignored.
- Mixed expansion: node 5; relations[20..23]=7, 0xFF, 9, 12; obstacle[9]=1, others 0; ready=1; start at cycle 0.
  - Neighbour 7 is accepted in cycle 5 and neighbour 12 in cycle 16.
  - done_out pulses in cycle 17 with n_vizinhos_out=2.
  - Exactly 4 relations reads (addresses 20–23) and 3 obstacle reads (7, 9, 12) occur.
- Backpressure: same setup with ready low for 3 cycles while 7 is presented → vizinho_out=7 holds stable, the count is unchanged, and done_out shifts to cycle 20.
- All null: node 2, relations[8..11]=0xFF → no valid, done_out in cycle 9, n_vizinhos_out=0.
- Start while busy: pulse start with node 3 in cycle 4 of the mixed expansion → ignored; the results equal the mixed case.
- Reset mid-operation: assert rst in ENTREGA → the next cycle has valid=0 and busy=0, no done_out is emitted, and a fresh start then completes normally.
